alu: RTL and testbench

- 32-bit MIPS-style execute-stage ALU.
- Covers add/sub, logic, set-less-than and shifts in one cycle, signed MULT in one cycle, and signed DIV over several cycles.
- MULT and DIV write the architectural HI/LO registers, which are held inside the block.
- Sits between the register-file operand muxes and the writeback stage.

---
 rtl/alu.sv | 214 +++++++++++++++++++++
 tb/tb_alu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// MIPS-style execute-stage ALU: single-cycle arithmetic/logic/shift/MULT,
// and an iterative restoring signed divider. HI/LO are held inside the block.
module alu #(
  parameter int WIDTH              = 32,
  parameter int DIV_BITS_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_srcA,
  input  logic [WIDTH-1:0] alu_srcB,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow,
  output logic             alu_done,
  output logic             alu_zero
);

  localparam int ITERS = WIDTH / DIV_BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS);
  localparam int SH_W  = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_DIV_BUSY = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dsr_zero_q, dsr_zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   sum, diff, a_mag, b_mag;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH:0]     rem_nxt;
  logic [WIDTH-1:0]   dvd_nxt, quo_fin, rem_fin;

  assign sum   = alu_srcA + alu_srcB;
  assign diff  = alu_srcA - alu_srcB;
  assign shamt = alu_srcA[SH_W-1:0];
  assign a_ext = {{WIDTH{alu_srcA[WIDTH-1]}}, alu_srcA};
  assign b_ext = {{WIDTH{alu_srcB[WIDTH-1]}}, alu_srcB};
  assign prod  = a_ext * b_ext;
  assign a_mag = alu_srcA[WIDTH-1] ? -alu_srcA : alu_srcA;
  assign b_mag = alu_srcB[WIDTH-1] ? -alu_srcB : alu_srcB;

  // One divider iteration: DIV_BITS_PER_CYCLE restoring shift/compare/subtract steps.
  always_comb begin
    // NOTE: blocking assignments here chain the unrolled steps within one cycle.
    rem_nxt = rem_q;
    dvd_nxt = dvd_q;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      rem_nxt = {rem_nxt[WIDTH-1:0], dvd_nxt[WIDTH-1]};
      dvd_nxt = {dvd_nxt[WIDTH-2:0], 1'b0};
      if (rem_nxt >= {1'b0, dsr_q}) begin
        rem_nxt    = rem_nxt - {1'b0, dsr_q};
        dvd_nxt[0] = 1'b1;
      end
    end
    quo_fin = neg_quo_q ? -dvd_nxt : dvd_nxt;
    rem_fin = neg_rem_q ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
  end

  always_comb begin
    // NOTE: every next-state variable gets a hold default first so no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    dsr_d      = dsr_q;
    a_d        = a_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dsr_zero_d = dsr_zero_q;
    result_d   = result_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          done_d = 1'b1;
          ovf_d  = 1'b0;
          case (alu_control)
            OP_ADD: begin
              result_d = sum;
              ovf_d    = (alu_srcA[WIDTH-1] == alu_srcB[WIDTH-1]) &&
                         (sum[WIDTH-1] != alu_srcA[WIDTH-1]);
            end
            OP_SUB: begin
              result_d = diff;
              ovf_d    = (alu_srcA[WIDTH-1] != alu_srcB[WIDTH-1]) &&
                         (diff[WIDTH-1] != alu_srcA[WIDTH-1]);
            end
            OP_AND:  result_d = alu_srcA & alu_srcB;
            OP_OR:   result_d = alu_srcA | alu_srcB;
            OP_NOR:  result_d = ~(alu_srcA | alu_srcB);
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, $signed(alu_srcA) < $signed(alu_srcB)};
            OP_SLL:  result_d = alu_srcB << shamt;
            OP_SRL:  result_d = alu_srcB >> shamt;
            OP_MULT: begin
              hi_d     = prod[2*WIDTH-1:WIDTH];
              lo_d     = prod[WIDTH-1:0];
              result_d = prod[WIDTH-1:0];
            end
            OP_DIV: begin
              // Outputs hold until the divide completes.
              done_d     = 1'b0;
              ovf_d      = ovf_q;
              state_d    = S_DIV_BUSY;
              cnt_d      = '0;
              dvd_d      = a_mag;
              rem_d      = '0;
              dsr_d      = b_mag;
              a_d        = alu_srcA;
              neg_quo_d  = alu_srcA[WIDTH-1] ^ alu_srcB[WIDTH-1];
              neg_rem_d  = alu_srcA[WIDTH-1];
              dsr_zero_d = (alu_srcB == '0);
            end
            default: result_d = '0;
          endcase
        end
      end

      S_DIV_BUSY: begin
        dvd_d = dvd_nxt;
        rem_d = rem_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          ovf_d   = 1'b0;
          if (dsr_zero_q) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = quo_fin;
            hi_d = rem_fin;
          end
          result_d = dsr_zero_q ? '1 : quo_fin;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      dsr_q      <= '0;
      a_q        <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dsr_zero_q <= 1'b0;
      result_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      dsr_q      <= dsr_d;
      a_q        <= a_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dsr_zero_q <= dsr_zero_d;
      result_q   <= result_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign alu_result = result_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign overflow   = ovf_q;
  assign alu_done   = done_q;
  assign alu_zero   = (result_q == '0);

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized ops against a
// plain-arithmetic reference model that tracks result/overflow/HI/LO.
module tb_alu;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;

  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  alu_control = '0;
  logic [31:0] alu_srcA = '0;
  logic [31:0] alu_srcB = '0;
  logic [31:0] alu_result, hi, lo;
  logic        overflow, alu_done, alu_zero;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what the outputs should currently show.
  logic [31:0] m_res = '0, m_hi = '0, m_lo = '0;
  logic        m_ovf = 1'b0;

  alu #(.WIDTH(32), .DIV_BITS_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .alu_control(alu_control),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_result(alu_result),
    .hi(hi), .lo(lo), .overflow(overflow), .alu_done(alu_done), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_ovf = 1'b0;
    case (op)
      OP_ADD:  begin t = sa + sb; m_res = t[31:0]; m_ovf = (t > MAX_S) || (t < MIN_S); end
      OP_SUB:  begin t = sa - sb; m_res = t[31:0]; m_ovf = (t > MAX_S) || (t < MIN_S); end
      OP_AND:  m_res = a & b;
      OP_OR:   m_res = a | b;
      OP_NOR:  m_res = ~(a | b);
      OP_SLT:  m_res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLL:  begin t = longint'(b) * (longint'(1) << a[4:0]); m_res = t[31:0]; end
      OP_SRL:  m_res = b / (32'd1 << a[4:0]);
      OP_MULT: begin t = sa * sb; m_hi = t[63:32]; m_lo = t[31:0]; m_res = m_lo; end
      OP_DIV: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else begin
          t = sa / sb; m_lo = t[31:0];
          t = sa % sb; m_hi = t[31:0];
        end
        m_res = m_lo;
      end
      default: m_res = '0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corner [6];
    corner = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Issues one op, scrambles inputs while busy, returns edges until alu_done (-1 on timeout).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    int edges;
    @(negedge clk);
    en = 1'b1; alu_control = op; alu_srcA = a; alu_srcB = b;
    @(posedge clk); #1;
    edges = 1;
    while (!alu_done && edges < 20) begin
      @(negedge clk);
      en = 1'b0; alu_control = 4'($urandom); alu_srcA = $urandom; alu_srcB = $urandom;
      @(posedge clk); #1;
      edges++;
    end
    lat = alu_done ? edges : -1;
    model(op, a, b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (alu_result !== 32'd0) begin n_bad++; $display("FAIL reset result: got %h want 0", alu_result); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL reset hilo: got %h/%h want 0/0", hi, lo); end
    n_cmp++; if (overflow !== 1'b0 || alu_done !== 1'b0) begin n_bad++; $display("FAIL reset flags: ovf %b done %b want 0 0", overflow, alu_done); end
    n_cmp++; if (alu_zero !== 1'b1) begin n_bad++; $display("FAIL reset zero: got %b want 1", alu_zero); end
    @(negedge clk); rst_n = 1'b1;
    m_res = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0;
  endtask

  task automatic test_arith();
    logic [3:0]  ops [3] = '{OP_ADD, OP_SUB, OP_SUB};
    logic [31:0] as  [3] = '{32'd15, 32'd25, 32'd10};
    logic [31:0] bs  [3] = '{32'd10, 32'd10, 32'd10};
    logic [31:0] ex  [3] = '{32'd25, 32'd15, 32'd0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], lat);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL arith%0d latency: got %0d want 1", i, lat); end
      n_cmp++; if (alu_result !== ex[i] || overflow !== 1'b0) begin n_bad++; $display("FAIL arith%0d result: got %h ovf %b want %h ovf 0", i, alu_result, overflow, ex[i]); end
      n_cmp++; if (alu_zero !== (ex[i] == 32'd0)) begin n_bad++; $display("FAIL arith%0d zero: got %b want %b", i, alu_zero, ex[i] == 32'd0); end
    end
  endtask

  task automatic test_logic_shift();
    logic [3:0]  ops [8] = '{OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLT, OP_SLT, OP_SLL, OP_SRL};
    logic [31:0] as  [8] = '{32'hC, 32'hC, 32'hC, 32'd5, 32'hFFFF_FFFF, 32'd10, 32'd2, 32'd2};
    logic [31:0] bs  [8] = '{32'hA, 32'hA, 32'hA, 32'd10, 32'd0, 32'd5, 32'd4, 32'd16};
    logic [31:0] ex  [8] = '{32'h8, 32'hE, 32'hFFFF_FFF1, 32'd1, 32'd1, 32'd0, 32'd16, 32'd4};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], lat);
      n_cmp++; if (alu_result !== ex[i] || lat !== 1) begin n_bad++; $display("FAIL logic%0d result: got %h lat %0d want %h lat 1", i, alu_result, lat, ex[i]); end
    end
  endtask

  task automatic test_mult();
    int lat;
    run_op(OP_MULT, 32'd7, 32'd3, lat);
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd21 || alu_result !== 32'd21 || lat !== 1) begin n_bad++; $display("FAIL mult_7x3: got hi %h lo %h res %h lat %0d want 0 15 15 1", hi, lo, alu_result, lat); end
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, lat);
    n_cmp++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL mult_neg: got hi %h lo %h want ffffffff fffffffa", hi, lo); end
    run_op(4'b1100, 32'd5, 32'd6, lat);
    n_cmp++; if (alu_result !== 32'd0 || overflow !== 1'b0 || lat !== 1) begin n_bad++; $display("FAIL undef_op: got res %h ovf %b lat %0d want 0 0 1", alu_result, overflow, lat); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL undef_op hilo: got %h/%h want ffffffff/fffffffa", hi, lo); end
  endtask

  task automatic test_div();
    logic [31:0] as [4] = '{32'd20, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    logic [31:0] bs [4] = '{32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] el [4] = '{32'd6, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] eh [4] = '{32'd2, 32'hFFFF_FFFF, 32'd5, 32'd0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(OP_DIV, as[i], bs[i], lat);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL div%0d latency: got %0d want 9", i, lat); end
      n_cmp++; if (lo !== el[i] || hi !== eh[i]) begin n_bad++; $display("FAIL div%0d hilo: got lo %h hi %h want %h %h", i, lo, hi, el[i], eh[i]); end
      n_cmp++; if (alu_result !== el[i]) begin n_bad++; $display("FAIL div%0d result: got %h want %h", i, alu_result, el[i]); end
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, lat);
    n_cmp++; if (alu_result !== 32'h8000_0000 || overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_add: got %h ovf %b want 80000000 1", alu_result, overflow); end
    run_op(OP_SUB, 32'h8000_0000, 32'd1, lat);
    n_cmp++; if (alu_result !== 32'h7FFF_FFFF || overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sub: got %h ovf %b want 7fffffff 1", alu_result, overflow); end
    run_op(OP_AND, 32'hC, 32'hA, lat);
    n_cmp++; if (alu_result !== 32'h8 || overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %h ovf %b want 8 0", alu_result, overflow); end
  endtask

  task automatic test_hold();
    @(negedge clk);
    en = 1'b0; alu_control = OP_ADD; alu_srcA = 32'd123; alu_srcB = 32'd456;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (alu_done !== 1'b0 || alu_result !== m_res || overflow !== m_ovf || hi !== m_hi || lo !== m_lo) begin
        n_bad++; $display("FAIL hold%0d: got done %b res %h ovf %b hi %h lo %h want 0 %h %b %h %h", i, alu_done, alu_result, overflow, hi, lo, m_res, m_ovf, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      op = 4'($urandom_range(0, 8)); a = pick(); b = pick();
      en = 1'b1; alu_control = op; alu_srcA = a; alu_srcB = b;
      @(posedge clk); #1;
      model(op, a, b);
      n_cmp++; if (alu_done !== 1'b1 || alu_result !== m_res || overflow !== m_ovf || hi !== m_hi || lo !== m_lo) begin
        n_bad++; $display("FAIL b2b%0d op %0d: got done %b res %h ovf %b hi %h lo %h want 1 %h %b %h %h", i, op, alu_done, alu_result, overflow, hi, lo, m_res, m_ovf, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    int lat;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15)); a = pick(); b = pick();
      run_op(op, a, b, lat);
      n_cmp++; if (lat !== ((op == OP_DIV) ? 9 : 1)) begin n_bad++; $display("FAIL rnd%0d op %0d latency: got %0d", i, op, lat); end
      n_cmp++; if (alu_result !== m_res || overflow !== m_ovf) begin n_bad++; $display("FAIL rnd%0d op %0d a %h b %h result: got %h ovf %b want %h ovf %b", i, op, a, b, alu_result, overflow, m_res, m_ovf); end
      n_cmp++; if (hi !== m_hi || lo !== m_lo) begin n_bad++; $display("FAIL rnd%0d op %0d a %h b %h hilo: got %h/%h want %h/%h", i, op, a, b, hi, lo, m_hi, m_lo); end
      n_cmp++; if (alu_zero !== (m_res == 32'd0)) begin n_bad++; $display("FAIL rnd%0d zero: got %b want %b", i, alu_zero, m_res == 32'd0); end
    end
  endtask

  task automatic test_reset_mid_div();
    int  lat;
    bit  seen_done;
    bit  moved;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, lat);
    @(negedge clk);
    en = 1'b1; alu_control = OP_DIV; alu_srcA = 32'd1000; alu_srcB = 32'd7;
    @(posedge clk);
    @(negedge clk); en = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    m_res = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0;
    n_cmp++; if (alu_result !== 32'd0 || hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL midrst values: got res %h hi %h lo %h want 0 0 0", alu_result, hi, lo); end
    n_cmp++; if (overflow !== 1'b0 || alu_done !== 1'b0 || alu_zero !== 1'b1) begin n_bad++; $display("FAIL midrst flags: got ovf %b done %b zero %b want 0 0 1", overflow, alu_done, alu_zero); end
    @(negedge clk); rst_n = 1'b1; en = 1'b0;
    seen_done = 1'b0; moved = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (alu_done) seen_done = 1'b1;
      if (alu_result !== 32'd0 || hi !== 32'd0 || lo !== 32'd0) moved = 1'b1;
    end
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL postrst done: got pulse want none"); end
    n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL postrst hold: outputs changed want all 0"); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic_shift();
    test_mult();
    test_div();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
